// File: rtl/l1_dcache_ctrl_if.sv
// Memory-bus and snoop bundle between the L1 data cache and the shared arbiter.
// master = cache side (issues requests, observes snoops), slave = arbiter side.
interface l1_dcache_ctrl_if #(
  parameter int n         = 32,
  parameter int addr_size = 10
);
  logic                 bus_req;
  logic                 bus_we;
  logic [addr_size-1:0] bus_addr;
  logic [n-1:0]         bus_wdata;
  logic                 bus_grant;
  logic                 bus_ack;
  logic [n-1:0]         bus_rdata;
  logic                 snoop_valid;
  logic [addr_size-1:0] snoop_addr;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_grant, bus_ack, bus_rdata, snoop_valid, snoop_addr
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_grant, bus_ack, bus_rdata, snoop_valid, snoop_addr
  );
endinterface

// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through / write-allocate L1 data
// cache controller. Loads hit with zero latency; misses and all stores go to
// the shared bus. Snooped writes from the other core invalidate matching lines.
module l1_dcache_ctrl #(
  parameter int n          = 32,
  parameter int addr_size  = 10,
  parameter int index_size = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_control,
  input  logic                 store_control,
  input  logic [addr_size-1:0] address,
  input  logic [n-1:0]         dmem_wdata,
  output logic [n-1:0]         dmem_rdata,
  output logic                 L1_busy,
  l1_dcache_ctrl_if.master     bus
);

  localparam int tag_size = addr_size - index_size;
  localparam int lines    = 1 << index_size;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE
  } state_t;

  state_t state_q, state_d;

  logic [lines-1:0]     valid_q, valid_d;
  logic [tag_size-1:0]  tag_q  [lines];
  logic [n-1:0]         data_q [lines];

  logic [addr_size-1:0] bus_addr_q, bus_addr_d;
  logic [n-1:0]         bus_wdata_q, bus_wdata_d;

  logic [index_size-1:0] cpu_index, fill_index, snoop_index;
  logic [tag_size-1:0]   cpu_tag, fill_tag, snoop_tag;
  logic                  hit;
  logic                  fill_en;
  logic [n-1:0]          fill_data;

  assign cpu_index   = address[index_size-1:0];
  assign cpu_tag     = address[addr_size-1:index_size];
  assign fill_index  = bus_addr_q[index_size-1:0];
  assign fill_tag    = bus_addr_q[addr_size-1:index_size];
  assign snoop_index = bus.snoop_addr[index_size-1:0];
  assign snoop_tag   = bus.snoop_addr[addr_size-1:index_size];

  assign hit        = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);
  assign dmem_rdata = data_q[cpu_index];

  // A line is written when the outstanding bus transfer completes: read data
  // for a miss fill, the store word for a write-through allocate.
  assign fill_en   = bus.bus_ack && ((state_q == RD_WAIT) || (state_q == WR_WAIT));
  assign fill_data = (state_q == RD_WAIT) ? bus.bus_rdata : bus_wdata_q;

  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;

  // Next-state, core stall and bus request decode.
  always_comb begin
    state_d      = state_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    L1_busy      = 1'b1;
    bus.bus_req  = 1'b0;
    bus.bus_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (store_control) begin
          // Stores always go to memory, and win over a simultaneous load.
          bus_addr_d  = address;
          bus_wdata_d = dmem_wdata;
          state_d     = WR_REQ;
        end else if (load_control) begin
          if (hit) begin
            L1_busy = 1'b0;
          end else begin
            bus_addr_d = address;
            state_d    = RD_REQ;
          end
        end else begin
          L1_busy = 1'b0;
        end
      end
      RD_REQ: begin
        bus.bus_req = 1'b1;
        if (bus.bus_grant) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        bus.bus_req = 1'b1;
        // The load stays presented and hits from the refilled line next cycle.
        if (bus.bus_ack) state_d = IDLE;
      end
      WR_REQ: begin
        bus.bus_req = 1'b1;
        bus.bus_we  = 1'b1;
        if (bus.bus_grant) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        bus.bus_req = 1'b1;
        bus.bus_we  = 1'b1;
        if (bus.bus_ack) state_d = DONE;
      end
      DONE: begin
        // One-cycle release so the core retires the store exactly once.
        L1_busy = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-line valid update: a completing fill sets valid, a matching snoop
  // clears it. The snoop is compared against the tag the line will hold after
  // this edge, so a snoop landing with the fill ack leaves the line invalid.
  for (genvar gi = 0; gi < lines; gi++) begin : g_line
    logic                fill_here;
    logic                snoop_here;
    logic [tag_size-1:0] line_tag;
    logic                line_valid_d;

    always_comb begin
      fill_here    = fill_en && (fill_index == index_size'(gi));
      line_tag     = fill_here ? fill_tag : tag_q[gi];
      snoop_here   = bus.snoop_valid && (snoop_index == index_size'(gi)) &&
                     (snoop_tag == line_tag);
      line_valid_d = valid_q[gi];
      if (fill_here)  line_valid_d = 1'b1;
      if (snoop_here) line_valid_d = 1'b0;
    end

    assign valid_d[gi] = line_valid_d;
  end

  // Control state, valid bits and bus request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Tag and data arrays; contents are meaningless while the line is invalid.
  always_ff @(posedge clk) begin
    if (fill_en && !reset) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= fill_data;
    end
  end

endmodule
